// File: rtl/rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_arbiter_if
// Request/grant bundle between a set of requesters and the round-robin
// arbiter that shares one resource among them.
//   req_i       : request vector, bit i = requester i (level-sensitive)
//   gnt_o       : one-hot grant, all-zero when idle
//   gnt_num_o   : index of the current (or last) owner
//   gnt_valid_o : high while any grant is active
// Modports:
//   master : requester side (drives req_i, observes the grant)
//   slave  : arbiter side (observes req_i, drives the grant)
// ---------------------------------------------------------------------------
interface rr_arbiter_if #(
  parameter int REQCNT   = 4,
  parameter int REQWIDTH = $clog2(REQCNT)
);
  logic [REQCNT-1:0]   req_i;
  logic [REQCNT-1:0]   gnt_o;
  logic [REQWIDTH-1:0] gnt_num_o;
  logic                gnt_valid_o;

  modport master (
    output req_i,
    input  gnt_o,
    input  gnt_num_o,
    input  gnt_valid_o
  );

  modport slave (
    input  req_i,
    output gnt_o,
    output gnt_num_o,
    output gnt_valid_o
  );
endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Sequential round-robin arbiter. Registers the current owner, keeps the
// grant while the owner holds its request, and forces rotation after
// MAX_HOLD consecutive grant cycles (0 = no limit). The priority pointer
// moves past every finished owner so all active requesters get served.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset
//   bus    : rr_arbiter_if.slave (req_i in; gnt_o, gnt_num_o, gnt_valid_o out)
// Outputs are decoded only from state registers, so there is no
// combinational path from req_i to the grant.
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int REQCNT   = 4,
  parameter int REQWIDTH = $clog2(REQCNT),
  parameter int MAX_HOLD = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  rr_arbiter_if.slave bus
);

  localparam int HOLDW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic [REQWIDTH-1:0] prior_reg, prior_next;
  logic [REQWIDTH-1:0] owner_reg, owner_next;
  logic [HOLDW-1:0]    hold_reg,  hold_next;

  logic [REQWIDTH-1:0] owner_inc;     // (owner + 1) mod REQCNT
  logic [REQWIDTH-1:0] search_start;
  logic                win_found;
  logic [REQWIDTH-1:0] win_idx;
  logic                timeout;
  logic                grant_end;
  logic [REQCNT-1:0]   gnt_vec;

  // Wrap explicitly at REQCNT so a non-power-of-two count never lets the
  // pointer land on a nonexistent requester.
  assign owner_inc = (owner_reg == REQWIDTH'(REQCNT - 1)) ? '0
                                                          : owner_reg + REQWIDTH'(1);

  // While granting, the only search whose result is used is the one at the
  // end of the grant, which must already see the advanced pointer. A dropped
  // owner request is already 0 in req_i, so no extra masking is needed; on a
  // timeout the owner stays visible and is found last, after everyone else.
  assign search_start = (state_reg == GRANT) ? owner_inc : prior_reg;

  // Circular first-set search starting at search_start. Iterating from the
  // farthest offset down lets the nearest requester overwrite the result.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = REQCNT - 1; i >= 0; i--) begin
      idx = int'(search_start) + i;
      if (idx >= REQCNT) begin
        idx = idx - REQCNT;
      end
      if (bus.req_i[idx]) begin
        win_found = 1'b1;
        win_idx   = REQWIDTH'(idx);
      end
    end
  end

  assign timeout   = (MAX_HOLD != 0) && (hold_reg == HOLDW'(MAX_HOLD - 1));
  assign grant_end = !bus.req_i[owner_reg] || timeout;

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    prior_next = prior_reg;
    owner_next = owner_reg;
    hold_next  = hold_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          owner_next = win_idx;
          hold_next  = '0;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (!grant_end) begin
          hold_next = hold_reg + HOLDW'(1);
        end else begin
          prior_next = owner_inc;
          if (win_found) begin
            // Hand over without an idle bubble.
            owner_next = win_idx;
            hold_next  = '0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      prior_reg <= '0;
      owner_reg <= '0;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      prior_reg <= prior_next;
      owner_reg <= owner_next;
      hold_reg  <= hold_next;
    end
  end

  // One-hot decode of the registered owner.
  for (genvar gi = 0; gi < REQCNT; gi++) begin : g_gnt
    assign gnt_vec[gi] = (state_reg == GRANT) && (owner_reg == REQWIDTH'(gi));
  end

  assign bus.gnt_o       = gnt_vec;
  assign bus.gnt_num_o   = owner_reg;
  assign bus.gnt_valid_o = (state_reg == GRANT);

endmodule

// File: tb/tb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter
// Directed bench for rr_arbiter: a 4-requester instance covers reset,
// rotation, timeout, simultaneous events and transient requests; a
// 3-requester instance covers the non-power-of-two wrap. Outputs are
// sampled 1 time unit after each rising edge; inputs change at that point.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rr_arbiter;

  logic clk;
  logic rst;

  rr_arbiter_if #(.REQCNT(4)) bus4 ();
  rr_arbiter_if #(.REQCNT(3)) bus3 ();

  rr_arbiter #(.REQCNT(4), .MAX_HOLD(16)) dut4 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus4)
  );

  rr_arbiter #(.REQCNT(3), .MAX_HOLD(16)) dut3 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int check_cnt = 0;

  // {gnt, gnt_num, gnt_valid} snapshots
  logic [6:0] obs4;
  logic [5:0] obs3;
  assign obs4 = {bus4.gnt_o, bus4.gnt_num_o, bus4.gnt_valid_o};
  assign obs3 = {bus3.gnt_o, bus3.gnt_num_o, bus3.gnt_valid_o};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus4.req_i = '0;
    bus3.req_i = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Expected 4-requester snapshot for an active owner e.
  function automatic logic [6:0] exp4(input int e);
    logic [3:0] g;
    g = 4'b0001 << e;
    return {g, 2'(e), 1'b1};
  endfunction

  function automatic logic [5:0] exp3(input int e);
    logic [2:0] g;
    g = 3'b001 << e;
    return {g, 2'(e), 1'b1};
  endfunction

  task automatic test_reset();
    logic [6:0] e;
    rst = 1'b1;
    bus4.req_i = '0;
    bus3.req_i = '0;
    step();
    check_cnt++;
    if (obs4 !== 7'b0) $display("FAIL reset_state: got %h expected %h", obs4, 7'b0);
    else begin pass_cnt++; $display("check reset_state ok"); end
    rst = 1'b0;
    bus4.req_i = 4'b0100;
    step();
    e = exp4(2);
    check_cnt++;
    if (obs4 !== e) $display("FAIL reset_owner2: got %h expected %h", obs4, e);
    else begin pass_cnt++; $display("check reset_owner2 ok"); end
    step();
    // Asynchronous reset mid-grant, checked before the next edge.
    #2 rst = 1'b1;
    #1;
    check_cnt++;
    if (obs4 !== 7'b0) $display("FAIL reset_async: got %h expected %h", obs4, 7'b0);
    else begin pass_cnt++; $display("check reset_async ok"); end
    step();
    rst = 1'b0;
    bus4.req_i = 4'b1111;
    step();
    e = exp4(0);
    check_cnt++;
    if (obs4 !== e) $display("FAIL reset_first_arb: got %h expected %h", obs4, e);
    else begin pass_cnt++; $display("check reset_first_arb ok"); end
  endtask

  task automatic test_rotation();
    logic [6:0] e;
    int seq [5] = '{0, 1, 2, 3, 0};
    do_reset();
    bus4.req_i = 4'b1111;
    step();
    for (int n = 0; n < 4; n++) begin
      for (int c = 0; c < 3; c++) begin
        e = exp4(seq[n]);
        check_cnt++;
        if (obs4 !== e) $display("FAIL rotation_hold n=%0d c=%0d: got %h expected %h", n, c, obs4, e);
        else begin pass_cnt++; $display("check rotation_hold n=%0d c=%0d ok", n, c); end
        if (c < 2) step();
      end
      bus4.req_i[seq[n]] = 1'b0;
      step();
      bus4.req_i[seq[n]] = 1'b1;
      e = exp4(seq[n+1]);
      check_cnt++;
      if (obs4 !== e) $display("FAIL rotation_handover n=%0d: got %h expected %h", n, obs4, e);
      else begin pass_cnt++; $display("check rotation_handover n=%0d ok", n); end
    end
  endtask

  task automatic test_timeout();
    logic [6:0] e;
    int owners [3] = '{0, 2, 0};
    do_reset();
    bus4.req_i = 4'b0101;
    step();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 16; i++) begin
        e = exp4(owners[p]);
        check_cnt++;
        if (obs4 !== e) $display("FAIL timeout_hold p=%0d i=%0d: got %h expected %h", p, i, obs4, e);
        else begin pass_cnt++; $display("check timeout_hold p=%0d i=%0d ok", p, i); end
        step();
      end
    end
    e = exp4(owners[2]);
    check_cnt++;
    if (obs4 !== e) $display("FAIL timeout_return: got %h expected %h", obs4, e);
    else begin pass_cnt++; $display("check timeout_return ok"); end
    // Solo requester: re-granted across timeouts with no gap.
    bus4.req_i = 4'b0001;
    for (int i = 0; i < 40; i++) begin
      step();
      e = exp4(0);
      check_cnt++;
      if (obs4 !== e) $display("FAIL timeout_solo i=%0d: got %h expected %h", i, obs4, e);
      else pass_cnt++;
    end
    $display("check timeout_solo done");
  endtask

  task automatic test_wrap3();
    logic [5:0] e;
    do_reset();
    bus3.req_i = 3'b100;
    step();
    e = exp3(2);
    check_cnt++;
    if (obs3 !== e) $display("FAIL wrap3_owner2: got %h expected %h", obs3, e);
    else begin pass_cnt++; $display("check wrap3_owner2 ok"); end
    bus3.req_i = 3'b011;
    step();
    e = exp3(0);
    check_cnt++;
    if (obs3 !== e) $display("FAIL wrap3_to0: got %h expected %h", obs3, e);
    else begin pass_cnt++; $display("check wrap3_to0 ok"); end
    bus3.req_i = 3'b110;
    step();
    e = exp3(1);
    check_cnt++;
    if (obs3 !== e) $display("FAIL wrap3_to1: got %h expected %h", obs3, e);
    else begin pass_cnt++; $display("check wrap3_to1 ok"); end
    bus3.req_i = 3'b101;
    step();
    e = exp3(2);
    check_cnt++;
    if (obs3 !== e) $display("FAIL wrap3_to2: got %h expected %h", obs3, e);
    else begin pass_cnt++; $display("check wrap3_to2 ok"); end
    bus3.req_i = 3'b001;
    step();
    e = exp3(0);
    check_cnt++;
    if (obs3 !== e) $display("FAIL wrap3_again0: got %h expected %h", obs3, e);
    else begin pass_cnt++; $display("check wrap3_again0 ok"); end
  endtask

  task automatic test_simultaneous();
    logic [6:0] e;
    do_reset();
    bus4.req_i = 4'b0010;
    step();
    bus4.req_i = 4'b0011;
    step();
    e = exp4(1);
    check_cnt++;
    if (obs4 !== e) $display("FAIL simul_owner1: got %h expected %h", obs4, e);
    else begin pass_cnt++; $display("check simul_owner1 ok"); end
    bus4.req_i = 4'b1001;
    step();
    e = exp4(3);
    check_cnt++;
    if (obs4 !== e) $display("FAIL simul_to3: got %h expected %h", obs4, e);
    else begin pass_cnt++; $display("check simul_to3 ok"); end
    bus4.req_i = 4'b0001;
    step();
    e = exp4(0);
    check_cnt++;
    if (obs4 !== e) $display("FAIL simul_to0: got %h expected %h", obs4, e);
    else begin pass_cnt++; $display("check simul_to0 ok"); end
  endtask

  task automatic test_transient();
    logic [6:0] e;
    do_reset();
    bus4.req_i = 4'b0001;
    step();
    bus4.req_i = 4'b0011;
    step();
    bus4.req_i = 4'b0001;
    step();
    step();
    e = exp4(0);
    check_cnt++;
    if (obs4 !== e) $display("FAIL transient_hold0: got %h expected %h", obs4, e);
    else begin pass_cnt++; $display("check transient_hold0 ok"); end
    bus4.req_i = 4'b0000;
    step();
    // Idle: no grant, index keeps the last owner.
    check_cnt++;
    if (obs4 !== 7'b0000_00_0) $display("FAIL transient_idle: got %h expected %h", obs4, 7'b0);
    else begin pass_cnt++; $display("check transient_idle ok"); end
    step();
    check_cnt++;
    if (obs4 !== 7'b0000_00_0) $display("FAIL transient_stay_idle: got %h expected %h", obs4, 7'b0);
    else begin pass_cnt++; $display("check transient_stay_idle ok"); end
  endtask

  initial begin
    rst = 1'b1;
    bus4.req_i = '0;
    bus3.req_i = '0;
    test_reset();
    test_rotation();
    test_timeout();
    test_wrap3();
    test_simultaneous();
    test_transient();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
